pio_input: RTL and testbench

- Avalon-MM slave input port; the read-side counterpart to the team's output PIO.
- Synchronises an external INPUT_WIDTH-bit bus into the clk domain and presents it over a MEMORY_WIDTH-bit data bus in address-indexed slices.
- Captures rising and/or falling edges per bit, and raises a maskable level interrupt to the Clarvi core.

---
 rtl/pio_pkg.sv | 18 +
 rtl/pio_sync_edge.sv | 47 ++++
 rtl/pio_input.sv | 119 +++++++++++
 tb/tb_pio_input.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared register map, edge-select bit positions and slice helper for the PIO input port.
package pio_pkg;

  localparam logic [3:0] ADDR_DATA = 4'h0;
  localparam logic [3:0] ADDR_MASK = 4'h4;
  localparam logic [3:0] ADDR_CAPT = 4'h8;
  localparam logic [3:0] ADDR_EDGE = 4'hC;
  localparam logic [3:0] ADDR_STAT = 4'hD;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;

  // Number of data-bus words needed to cover the input bus.
  function automatic int sliceCount(input int inputWidth, input int memoryWidth);
    return (inputWidth + memoryWidth - 1) / memoryWidth;
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Synchronises an asynchronous bus into clk and reports per-bit rising/falling edges,
// suppressed until the synchroniser has flushed its reset contents.
module pio_sync_edge #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int PRIME_MAX = STAGES + 1;
  localparam int CW        = $clog2(PRIME_MAX + 1);

  logic [WIDTH-1:0] stages_q [STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [CW-1:0]    prime_q, prime_d;
  logic             primed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stages_q[i] <= '0;
      prev_q  <= '0;
      prime_q <= '0;
    end else begin
      stages_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) stages_q[i] <= stages_q[i-1];
      prev_q  <= stages_q[STAGES-1];
      prime_q <= prime_d;
    end
  end

  // An input already high at reset release would otherwise look like a rising edge.
  always_comb begin
    prime_d = prime_q;
    if (!primed) prime_d = prime_q + 1'b1;
  end

  assign primed = (prime_q == CW'(PRIME_MAX));
  assign sync_o = stages_q[STAGES-1];
  assign rise_o = primed ? (sync_o & ~prev_q) : '0;
  assign fall_o = primed ? (~sync_o & prev_q) : '0;

endmodule

// File: rtl/pio_input.sv
// Avalon-MM input PIO: synchronised data, per-bit edge capture with W1C clear,
// and a masked level interrupt.
module pio_input
  import pio_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int MEMORY_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              avs_address,
  input  logic                    avs_byteenable,
  input  logic                    avs_write_n,
  input  logic [MEMORY_WIDTH-1:0] avs_writedata,
  input  logic                    avs_chipselect,
  input  logic                    avs_read_n,
  output logic [MEMORY_WIDTH-1:0] avs_readdata,
  output logic                    ins_irq,
  input  logic [INPUT_WIDTH-1:0]  coe_in_port
);

  localparam int SLICES = sliceCount(INPUT_WIDTH, MEMORY_WIDTH);
  localparam int PAD_W  = 4 * MEMORY_WIDTH;

  logic [INPUT_WIDTH-1:0]  sync, rise, fall, det;
  logic [INPUT_WIDTH-1:0]  mask_q, mask_d, capture_q, capture_d;
  logic [INPUT_WIDTH-1:0]  laneSel, laneData;
  logic [1:0]              edgeSel_q, edgeSel_d;
  logic                    irq_q;
  logic [MEMORY_WIDTH-1:0] readData_q, readData_d;
  logic [1:0]              region, slice;
  logic                    wrEn, rdEn;

  // Places a data-bus word onto the input-bit positions of the addressed slice.
  function automatic logic [INPUT_WIDTH-1:0] spread(input logic [1:0] sel,
                                                    input logic [MEMORY_WIDTH-1:0] data);
    logic [INPUT_WIDTH-1:0] result;
    result = '0;
    for (int i = 0; i < INPUT_WIDTH; i++)
      if (int'(sel) == i / MEMORY_WIDTH) result[i] = data[i % MEMORY_WIDTH];
    return result;
  endfunction

  function automatic logic [MEMORY_WIDTH-1:0] gather(input logic [1:0] sel,
                                                     input logic [INPUT_WIDTH-1:0] vec);
    logic [PAD_W-1:0] pad;
    pad = PAD_W'(vec);
    if (int'(sel) >= SLICES) return '0;
    case (sel)
      2'd0:    return pad[0              +: MEMORY_WIDTH];
      2'd1:    return pad[MEMORY_WIDTH   +: MEMORY_WIDTH];
      2'd2:    return pad[2*MEMORY_WIDTH +: MEMORY_WIDTH];
      default: return pad[3*MEMORY_WIDTH +: MEMORY_WIDTH];
    endcase
  endfunction

  pio_sync_edge #(
    .WIDTH (INPUT_WIDTH),
    .STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset_n(reset_n),
    .async_i(coe_in_port),
    .sync_o (sync),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign region   = avs_address[3:2];
  assign slice    = avs_address[1:0];
  assign wrEn     = avs_chipselect & ~avs_write_n & avs_byteenable;
  assign rdEn     = avs_chipselect & ~avs_read_n;
  assign laneSel  = spread(slice, '1);
  assign laneData = spread(slice, avs_writedata);
  assign det      = (rise & {INPUT_WIDTH{edgeSel_q[EDGE_RISE]}})
                  | (fall & {INPUT_WIDTH{edgeSel_q[EDGE_FALL]}});

  // A fresh edge is ORed in after the W1C so it survives a same-cycle clear.
  always_comb begin
    mask_d     = mask_q;
    capture_d  = capture_q | det;
    edgeSel_d  = edgeSel_q;
    readData_d = readData_q;
    if (wrEn) begin
      if (region == ADDR_MASK[3:2]) mask_d    = (mask_q & ~laneSel) | laneData;
      if (region == ADDR_CAPT[3:2]) capture_d = (capture_q & ~laneData) | det;
      if (avs_address == ADDR_EDGE) edgeSel_d = avs_writedata[1:0];
    end
    if (rdEn) begin
      readData_d = '0;
      if (region == ADDR_DATA[3:2])      readData_d      = gather(slice, sync);
      else if (region == ADDR_MASK[3:2]) readData_d      = gather(slice, mask_q);
      else if (region == ADDR_CAPT[3:2]) readData_d      = gather(slice, capture_q);
      else if (avs_address == ADDR_EDGE) readData_d[1:0] = edgeSel_q;
      else if (avs_address == ADDR_STAT) readData_d[0]   = irq_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      capture_q  <= '0;
      edgeSel_q  <= '0;
      irq_q      <= 1'b0;
      readData_q <= '0;
    end else begin
      mask_q     <= mask_d;
      capture_q  <= capture_d;
      edgeSel_q  <= edgeSel_d;
      irq_q      <= |(capture_q & mask_q);
      readData_q <= readData_d;
    end
  end

  assign avs_readdata = readData_q;
  assign ins_irq      = irq_q;

endmodule

// File: tb/tb_pio_input.sv
// Scoreboard bench for pio_input: reads and interrupt probes queue their expected
// values; a negedge monitor pops and compares them.
module tb_pio_input;
  import pio_pkg::*;

  localparam int IW = 24;
  localparam int MW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    avs_address = '0;
  logic          avs_byteenable = 1'b0;
  logic          avs_write_n = 1'b1;
  logic [MW-1:0] avs_writedata = '0;
  logic          avs_chipselect = 1'b0;
  logic          avs_read_n = 1'b1;
  logic [MW-1:0] avs_readdata;
  logic          ins_irq;
  logic [IW-1:0] coe_in_port = '1;

  typedef struct {
    string         name;
    logic [MW-1:0] exp;
  } rdExp_t;

  typedef struct {
    string         name;
    bit            isIrq;
    logic [MW-1:0] exp;
  } probe_t;

  rdExp_t readQ[$];
  probe_t probeQ[$];
  int     nVectors = 0;
  int     nFail = 0;
  logic   rdLatched;

  pio_input #(
    .INPUT_WIDTH (IW),
    .MEMORY_WIDTH(MW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_byteenable(avs_byteenable),
    .avs_write_n   (avs_write_n),
    .avs_writedata (avs_writedata),
    .avs_chipselect(avs_chipselect),
    .avs_read_n    (avs_read_n),
    .avs_readdata  (avs_readdata),
    .ins_irq       (ins_irq),
    .coe_in_port   (coe_in_port)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) rdLatched <= 1'b0;
    else          rdLatched <= avs_chipselect & ~avs_read_n;

  task automatic checkOutput(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    nVectors++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Read data is valid at the negedge after the edge that sampled the strobe.
  always @(negedge clk) begin
    rdExp_t e;
    probe_t p;
    if (rdLatched) begin
      if (readQ.size() == 0) begin
        nVectors++;
        nFail++;
        $display("[TB] FAIL unexpected-read: got %h, required no read", avs_readdata);
      end else begin
        e = readQ.pop_front();
        checkOutput(e.name, avs_readdata, e.exp);
      end
    end
    while (probeQ.size() > 0) begin
      p = probeQ.pop_front();
      checkOutput(p.name, p.isIrq ? {{(MW-1){1'b0}}, ins_irq} : avs_readdata, p.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cs, input logic rdN, input logic wrN, input logic be,
                               input logic [3:0] addr, input logic [MW-1:0] data);
    avs_chipselect = cs;
    avs_read_n     = rdN;
    avs_write_n    = wrN;
    avs_byteenable = be;
    avs_address    = addr;
    avs_writedata  = data;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, '0);
  endtask

  task automatic doWrite(input logic [3:0] addr, input logic [MW-1:0] data);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, addr, data);
    tick();
    idle();
  endtask

  task automatic doRead(input string name, input logic [3:0] addr, input logic [MW-1:0] exp);
    readQ.push_back('{name: name, exp: exp});
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, addr, '0);
    tick();
    idle();
  endtask

  task automatic doReadWrite(input string name, input logic [3:0] addr,
                             input logic [MW-1:0] data, input logic [MW-1:0] exp);
    readQ.push_back('{name: name, exp: exp});
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, addr, data);
    tick();
    idle();
  endtask

  task automatic probeIrq(input string name, input logic exp);
    probeQ.push_back('{name: name, isIrq: 1'b1, exp: {{(MW-1){1'b0}}, exp}});
  endtask

  task automatic probeData(input string name, input logic [MW-1:0] exp);
    probeQ.push_back('{name: name, isIrq: 1'b0, exp: exp});
  endtask

  task automatic printSummary();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
  endtask

  initial begin
    #200000;
    nFail++;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    printSummary();
    $finish;
  end

  initial begin
    $display("[TB] start");
    repeat (3) tick();

    // Priming: inputs high through reset release, edges enabled on the first cycle.
    reset_n = 1'b1;
    doWrite(ADDR_EDGE, 16'h0003);
    doWrite(ADDR_MASK, 16'hFFFF);
    doWrite(ADDR_MASK + 4'h1, 16'hFFFF);
    for (int i = 0; i < 20; i++) begin
      probeIrq("prime-irq", 1'b0);
      tick();
    end
    doRead("prime-capt0", ADDR_CAPT, 16'h0000);
    doRead("prime-capt1", ADDR_CAPT + 4'h1, 16'h0000);
    doWrite(ADDR_EDGE, 16'h0000);
    doWrite(ADDR_MASK, 16'h0000);
    doWrite(ADDR_MASK + 4'h1, 16'h0000);

    // Sync latency: one cycle too early still sees the old value.
    coe_in_port = 24'h00A5A5;
    tick();
    doRead("data-early", ADDR_DATA, 16'hFFFF);
    doRead("data-a5a5", ADDR_DATA, 16'hA5A5);
    doRead("data-slice1", ADDR_DATA + 4'h1, 16'h0000);

    // Rising-edge interrupt on bit0.
    doWrite(ADDR_EDGE, 16'h0001);
    doWrite(ADDR_MASK, 16'h0001);
    coe_in_port = 24'h00A5A4;
    repeat (4) tick();
    coe_in_port = 24'h00A5A5;
    tick();
    tick();
    tick();
    probeIrq("rise-irq-early", 1'b0);
    tick();
    probeIrq("rise-irq", 1'b1);
    doRead("rise-capt0", ADDR_CAPT, 16'h0001);
    doRead("rise-status", ADDR_STAT, 16'h0001);
    doWrite(ADDR_CAPT, 16'h0001);
    probeIrq("w1c-irq-hold", 1'b1);
    tick();
    probeIrq("w1c-irq-clear", 1'b0);
    doRead("w1c-capt0", ADDR_CAPT, 16'h0000);

    // Falling edge on bit3 with the interrupt masked off.
    doWrite(ADDR_EDGE, 16'h0000);
    coe_in_port = 24'h00A5AD;
    repeat (4) tick();
    doWrite(ADDR_EDGE, 16'h0002);
    doWrite(ADDR_MASK, 16'h0000);
    coe_in_port = 24'h00A5A5;
    repeat (4) tick();
    doRead("fall-capt0", ADDR_CAPT, 16'h0008);
    probeIrq("fall-irq-masked", 1'b0);
    doRead("fall-status", ADDR_STAT, 16'h0000);
    doWrite(ADDR_CAPT, 16'hFFFF);
    doRead("fall-cleared", ADDR_CAPT, 16'h0000);

    // W1C on bit5 lands in the same cycle its rising edge is detected.
    doWrite(ADDR_EDGE, 16'h0001);
    coe_in_port = 24'h00A585;
    repeat (4) tick();
    coe_in_port = 24'h00A5A5;
    tick();
    tick();
    doWrite(ADDR_CAPT, 16'h0020);
    doRead("collide-capt0", ADDR_CAPT, 16'h0020);
    doWrite(ADDR_CAPT, 16'h0020);
    doRead("collide-cleared", ADDR_CAPT, 16'h0000);

    // Wide bus: partial slice 1, empty slices 2-3, unmapped addresses.
    coe_in_port = 24'hABCDEF;
    repeat (4) tick();
    doRead("wide-data0", ADDR_DATA, 16'hCDEF);
    doRead("wide-data1", ADDR_DATA + 4'h1, 16'h00AB);
    doRead("wide-data2", ADDR_DATA + 4'h2, 16'h0000);
    doRead("wide-data3", ADDR_DATA + 4'h3, 16'h0000);
    doRead("wide-capt0", ADDR_CAPT, 16'h484A);
    doRead("wide-capt1", ADDR_CAPT + 4'h1, 16'h00AB);
    doWrite(ADDR_MASK + 4'h1, 16'hFFFF);
    doRead("wide-mask1", ADDR_MASK + 4'h1, 16'h00FF);
    doWrite(ADDR_MASK + 4'h2, 16'hFFFF);
    doRead("wide-mask2", ADDR_MASK + 4'h2, 16'h0000);
    doWrite(4'hE, 16'hFFFF);
    doRead("unmapped-e", 4'hE, 16'h0000);
    doRead("unmapped-f", 4'hF, 16'h0000);
    doRead("edge-sel", ADDR_EDGE, 16'h0001);
    doRead("wide-status", ADDR_STAT, 16'h0001);
    probeIrq("wide-irq", 1'b1);

    // Read and write of MASK0 in one cycle returns the old value; be=0 write ignored.
    doReadWrite("rw-same-cycle", ADDR_MASK, 16'h1234, 16'h0000);
    doRead("rw-after", ADDR_MASK, 16'h1234);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, ADDR_MASK, 16'hFFFF);
    tick();
    idle();
    doRead("be-off-ignored", ADDR_MASK, 16'h1234);

    // Asynchronous reset mid-operation.
    doRead("pre-reset-status", ADDR_STAT, 16'h0001);
    tick();
    reset_n = 1'b0;
    probeData("reset-readdata", 16'h0000);
    probeIrq("reset-irq", 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    doRead("reset-edge", ADDR_EDGE, 16'h0000);
    doRead("reset-mask0", ADDR_MASK, 16'h0000);
    doRead("reset-capt1", ADDR_CAPT + 4'h1, 16'h0000);

    repeat (4) tick();
    if (readQ.size() != 0 || probeQ.size() != 0) begin
      nVectors++;
      nFail++;
      $display("[TB] FAIL drain: got %0d pending, required 0", readQ.size() + probeQ.size());
    end
    printSummary();
    $finish;
  end

endmodule
